// File: rtl/utils.sv
// Shared constants, parser state type and ASCII hex decoding for the
// serial input loader.
package utils;

    localparam int         DEPTH_DEF  = 460;
    localparam logic [7:0] ASCII_BANG = 8'h21;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO
    } parse_state_e;

    // Returns {valid, nibble} for '0'-'9', 'A'-'F', 'a'-'f'.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) ||
                     (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte strobe on a good stop bit and a frame_err strobe on a bad one.
module uart_rx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    rx_state_e     state_q, state_d;
    logic          meta_q, sync_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/input_loader.sv
// Loads button frames sent as ASCII hex pairs over UART into a playback
// memory with a synchronous read port.
module input_loader
    import utils::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic [8:0] rd_addr,
    output logic [5:0] rd_data,
    output logic       load_done,
    output logic [8:0] frame_count,
    output logic       err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ferr;
    logic [4:0]   hex;

    parse_state_e state_q, state_d;
    logic [8:0]   count_q, count_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [1:0]   hi_q, hi_d;
    logic [5:0]   rd_data_q;
    logic         we;
    logic [5:0]   wdata;

    logic [5:0]   mem [DEPTH];

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (uart_rx),
        .data      (rx_data),
        .data_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    assign hex = hex_decode(rx_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
        end
    end

    // The write pointer and frame_count are the same register: it only
    // advances on a stored frame, so it saturates at DEPTH.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q | rx_ferr;
        hi_d    = hi_q;
        we      = 1'b0;
        wdata   = {hi_q, hex[3:0]};
        if (rx_valid) begin
            if (rx_data == ASCII_BANG) begin
                count_d = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
                state_d = HI;
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    HI: begin
                        unique case (1'b1)
                            (rx_data[7:2] == 6'b001100): begin
                                hi_d    = rx_data[1:0];
                                state_d = LO;
                            end
                            (rx_data == ASCII_LF): begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                            (rx_data == ASCII_CR): begin
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                    LO: begin
                        unique case (1'b1)
                            hex[4]: begin
                                state_d = HI;
                                if (count_q < DEPTH_W) begin
                                    we      = 1'b1;
                                    count_d = count_q + 9'd1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            (rx_data == ASCII_CR): begin
                            end
                            (rx_data == ASCII_LF): begin
                                err_d   = 1'b1;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = HI;
                            end
                        endcase
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[count_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_addr < DEPTH_W) begin
            rd_data_q <= mem[rd_addr[AW-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data     = rd_data_q;
    assign load_done   = done_q;
    assign frame_count = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_input_loader.sv
// Bench for input_loader: directed load table, framing/reset/overflow
// sequences, then random byte streams against a behavioural model.
module tb_input_loader;

    localparam int CPB   = 16;
    localparam int DEPTH = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [8:0] rd_addr;
    logic [5:0] rd_data;
    logic       load_done;
    logic [8:0] frame_count;
    logic       err;

    int checks = 0;
    int errors = 0;

    input_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .load_done  (load_done),
        .frame_count(frame_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      msg;
        logic [5:0] m0;
        logic [5:0] m1;
        int         fc;
        logic       done;
        logic       er;
    } vec_t;

    // reference model state
    int         m_mode;
    int         m_fc;
    bit         m_done;
    bit         m_err;
    int         m_hi;
    logic [5:0] m_mem [DEPTH];
    bit         m_known [DEPTH];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB + 8) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b0);
        end
    endtask

    task automatic read_chk(input string name, input logic [8:0] a,
                            input logic [5:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(name, {10'd0, rd_data}, {10'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    // mode: 0 waiting for '!', 1 expecting high digit, 2 expecting low digit
    task automatic model_byte(input logic [7:0] b, input bit bad);
        int h;
        if (bad) begin
            m_err = 1'b1;
            return;
        end
        if (b == 8'h21) begin
            m_mode = 1; m_fc = 0; m_done = 0; m_err = 0;
            return;
        end
        h = hexval(b);
        if (m_mode == 1) begin
            if (b >= "0" && b <= "3") begin
                m_hi = int'(b) - 48;
                m_mode = 2;
            end else if (b == 8'h0A) begin
                m_done = 1; m_mode = 0;
            end else if (b != 8'h0D) begin
                m_err = 1;
            end
        end else if (m_mode == 2) begin
            if (h >= 0) begin
                if (m_fc < DEPTH) begin
                    m_mem[m_fc]   = 6'(m_hi * 16 + h);
                    m_known[m_fc] = 1'b1;
                    m_fc++;
                end else begin
                    m_err = 1;
                end
                m_mode = 1;
            end else if (b == 8'h0A) begin
                m_err = 1; m_done = 1; m_mode = 0;
            end else if (b != 8'h0D) begin
                m_err = 1; m_mode = 1;
            end
        end
    endtask

    vec_t vt[4];

    initial begin
        logic [7:0] b;
        bit         bad;
        int         r;
        string      hexs;

        hexs = "0123456789abcdefABCDEF";
        vt[0] = '{"!2A05\n",     6'h2A, 6'h05, 2, 1'b1, 1'b0};
        vt[1] = '{"!3f\015\n",   6'h3F, 6'h00, 1, 1'b1, 1'b0};
        vt[2] = '{"!401\n",      6'h01, 6'h00, 1, 1'b1, 1'b1};
        vt[3] = '{"!1122\n",     6'h11, 6'h22, 2, 1'b1, 1'b0};

        reset   = 1'b1;
        uart_rx = 1'b1;
        rd_addr = '0;
        do_reset();
        @(negedge clk);
        chk("rst_done", {15'd0, load_done}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_fc", {7'd0, frame_count}, 16'd0);
        chk("rst_rd", {10'd0, rd_data}, 16'd0);

        for (int v = 0; v < 4; v++) begin
            send_str(vt[v].msg);
            chk("vec_done", {15'd0, load_done}, {15'd0, vt[v].done});
            chk("vec_err", {15'd0, err}, {15'd0, vt[v].er});
            chk("vec_fc", {7'd0, frame_count}, 16'(vt[v].fc));
            read_chk("vec_mem0", 9'd0, vt[v].m0);
            if (vt[v].fc >= 2) read_chk("vec_mem1", 9'd1, vt[v].m1);
        end

        // bad stop bit on '!' while idle: err only
        send_byte(8'h21, 1'b1);
        chk("ferr_err", {15'd0, err}, 16'd1);
        chk("ferr_done", {15'd0, load_done}, 16'd1);
        send_str("05");
        chk("ferr_fc", {7'd0, frame_count}, 16'd2);
        read_chk("ferr_mem0", 9'd0, 6'h11);

        // reset in the middle of a '!' byte
        @(negedge clk);
        rd_addr = 9'd1;
        uart_rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_rd", {10'd0, rd_data}, 16'd0);
        chk("mid_rst_fc", {7'd0, frame_count}, 16'd0);
        chk("mid_rst_done", {15'd0, load_done}, 16'd0);
        chk("mid_rst_err", {15'd0, err}, 16'd0);
        reset = 1'b0;
        read_chk("keep_mem1", 9'd1, 6'h22);
        read_chk("keep_mem0", 9'd0, 6'h11);
        read_chk("oob_depth", 9'(DEPTH), 6'h00);
        read_chk("oob_max", 9'h1FF, 6'h00);

        // overflow: DEPTH+1 pairs
        send_byte(8'h21, 1'b0);
        for (int i = 0; i < DEPTH; i++) send_str("01");
        chk("full_fc", {7'd0, frame_count}, 16'(DEPTH));
        chk("full_err", {15'd0, err}, 16'd0);
        send_str("01\n");
        chk("ovf_fc", {7'd0, frame_count}, 16'(DEPTH));
        chk("ovf_err", {15'd0, err}, 16'd1);
        chk("ovf_done", {15'd0, load_done}, 16'd1);
        read_chk("ovf_last", 9'(DEPTH - 1), 6'h01);

        // random streams against the model
        do_reset();
        m_mode = 0; m_fc = 0; m_done = 0; m_err = 0; m_hi = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 6'h01;
            m_known[i] = 1'b1;
        end
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5) b = 8'h21;
            else if (r < 11) b = 8'h0A;
            else if (r < 15) b = 8'h0D;
            else if (r < 22) b = 8'($urandom_range(0, 255));
            else if (r < 55) b = 8'(48 + $urandom_range(0, 3));
            else b = hexs[$urandom_range(0, hexs.len() - 1)];
            bad = ($urandom_range(0, 29) == 0);
            send_byte(b, bad);
            model_byte(b, bad);
            chk("rnd_done", {15'd0, load_done}, {15'd0, m_done});
            chk("rnd_err", {15'd0, err}, {15'd0, m_err});
            chk("rnd_fc", {7'd0, frame_count}, 16'(m_fc));
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (m_known[a]) read_chk("rnd_mem", 9'(a), m_mem[a]);
        end
        read_chk("rnd_oob", 9'(DEPTH + 3), 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
